// File: rtl/d5m_config_sequencer_pkg.sv
// Shared types, constants and register table for the D5M configuration sequencer.
// Defining D5M_CONFIG_SOFT_RESET_EN prepends a sensor soft-reset pulse (0x0D=1, 0x0D=0).
package pkgD5MConfig;

   typedef struct packed {
      logic [7:0]  addr;
      logic [15:0] data;
   } regWrite_t;

   typedef enum logic [2:0] {
      StIdle,
      StPwrupWait,
      StIssue,
      StWaitDone,
      StGap,
      StDone,
      StError
   } seqState_t;

   localparam logic [7:0] EXPOSURE_ADDR   = 8'h09;
   localparam logic [7:0] SOFT_RESET_ADDR = 8'h0D;

   localparam int unsigned BASE_LEN = 14;
`ifdef D5M_CONFIG_SOFT_RESET_EN
   localparam int unsigned PRE_LEN = 2;
`else
   localparam int unsigned PRE_LEN = 0;
`endif
   localparam int unsigned TABLE_LEN = PRE_LEN + BASE_LEN;

   function automatic regWrite_t baseEntry(input logic [4:0] idx);
      regWrite_t e;
      case (idx)
         5'd0:    e = {8'h01, 16'h0036};  // row start
         5'd1:    e = {8'h02, 16'h0010};  // column start
         5'd2:    e = {8'h03, 16'h0797};  // row size
         5'd3:    e = {8'h04, 16'h0A1F};  // column size
         5'd4:    e = {8'h05, 16'h0000};  // horizontal blank
         5'd5:    e = {8'h06, 16'h0019};  // vertical blank
         5'd6:    e = {8'h09, 16'h0400};  // shutter width
         5'd7:    e = {8'h20, 16'hC000};  // read mode
         5'd8:    e = {8'h22, 16'h0000};  // row address mode
         5'd9:    e = {8'h23, 16'h0000};  // column address mode
         5'd10:   e = {8'h2B, 16'h0013};  // green1 gain
         5'd11:   e = {8'h2C, 16'h0016};  // blue gain
         5'd12:   e = {8'h2D, 16'h0016};  // red gain
         5'd13:   e = {8'h2E, 16'h0013};  // green2 gain
         default: e = '0;
      endcase
      return e;
   endfunction

   function automatic regWrite_t tableEntry(input logic [4:0] idx);
      regWrite_t e;
`ifdef D5M_CONFIG_SOFT_RESET_EN
      if (idx == 5'd0)      e = {SOFT_RESET_ADDR, 16'h0001};
      else if (idx == 5'd1) e = {SOFT_RESET_ADDR, 16'h0000};
      else                  e = baseEntry(idx - 5'd2);
`else
      e = baseEntry(idx);
`endif
      return e;
   endfunction

endpackage

// File: rtl/d5m_config_sequencer_delay_counter.sv
// Loadable down-counter with zero flag; holds at zero until reloaded.
module d5m_config_delay_counter #(
   parameter int unsigned Width = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [Width-1:0] loadValue,
   output logic             zero
);

   logic [Width-1:0] count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= loadValue;
      end else if (count_q != '0) begin
         count_q <= count_q - Width'(1);
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/d5m_config_sequencer.sv
// TRDB-D5M configuration sequencer: walks the register table, retries NACKs, then services
// exposure updates. Optional soft-reset prefix via D5M_CONFIG_SOFT_RESET_EN (see package).
module d5m_config_sequencer
   import pkgD5MConfig::*;
#(
   parameter int unsigned POWERUP_DELAY_CC     = 50000,
   parameter int unsigned INTER_WRITE_DELAY_CC = 64,
   parameter int unsigned MAX_RETRIES          = 3
) (
   input  logic        piul1Clock,
   input  logic        piul1Reset,
   input  logic        piul1Start,
   input  logic        piul1ExposureUpdate,
   input  logic [15:0] piul16Exposure,
   output logic        poul1WrReq,
   output logic [7:0]  poul8WrAddr,
   output logic [15:0] poul16WrData,
   input  logic        piul1WrDone,
   input  logic        piul1WrNack,
   output logic        poul1Busy,
   output logic        poul1ConfigDone,
   output logic        poul1Error,
   output logic [4:0]  poul5TableIndex
);

   localparam int unsigned MAX_DELAY = (POWERUP_DELAY_CC > INTER_WRITE_DELAY_CC) ?
                                       POWERUP_DELAY_CC : INTER_WRITE_DELAY_CC;
   localparam int unsigned CNT_W = $clog2(MAX_DELAY + 1);
   localparam logic [CNT_W-1:0] PWRUP_LOAD = CNT_W'(POWERUP_DELAY_CC - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(INTER_WRITE_DELAY_CC - 1);
   localparam logic [4:0] LAST_IDX  = 5'(TABLE_LEN - 1);
   localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRIES);

   seqState_t   state_q, state_d;
   logic [4:0]  index_q, index_d;
   logic [3:0]  retry_q, retry_d;
   logic        expoActive_q, expoActive_d;
   logic        expoPending_q, expoPending_d;
   logic [15:0] expoValue_q, expoValue_d;
   logic        configDone_q, configDone_d;
   logic [7:0]  wrAddr_q, wrAddr_d;
   logic [15:0] wrData_q, wrData_d;
   logic             cntLoad;
   logic [CNT_W-1:0] cntLoadValue;
   logic             cntZero;
   logic             startOk;
   regWrite_t        entry;

   d5m_config_delay_counter #(
      .Width(CNT_W)
   ) uDelay (
      .clk      (piul1Clock),
      .rst      (piul1Reset),
      .load     (cntLoad),
      .loadValue(cntLoadValue),
      .zero     (cntZero)
   );

   assign startOk = piul1Start && (state_q inside {StIdle, StDone, StError});

   always_comb begin
      state_d       = state_q;
      index_d       = index_q;
      retry_d       = retry_q;
      expoActive_d  = expoActive_q;
      expoPending_d = expoPending_q;
      expoValue_d   = expoValue_q;
      configDone_d  = configDone_q;
      wrAddr_d      = wrAddr_q;
      wrData_d      = wrData_q;
      cntLoad       = 1'b0;
      cntLoadValue  = GAP_LOAD;
      entry         = tableEntry(index_q);

      // An honoured Start discards any pending exposure, even one arriving this cycle
      if (startOk) begin
         expoPending_d = 1'b0;
      end else if (piul1ExposureUpdate) begin
         expoPending_d = 1'b1;
         expoValue_d   = piul16Exposure;
      end

      unique case (state_q)
         StIdle: begin
            state_d      = StPwrupWait;
            index_d      = '0;
            cntLoad      = 1'b1;
            cntLoadValue = PWRUP_LOAD;
         end
         StPwrupWait: begin
            if (cntZero) begin
               state_d      = StIssue;
               index_d      = '0;
               retry_d      = '0;
               expoActive_d = 1'b0;
            end
         end
         StIssue: begin
            state_d = StWaitDone;
            if (expoActive_q) begin
               wrAddr_d = EXPOSURE_ADDR;
               wrData_d = expoValue_q;
            end else begin
               wrAddr_d = entry.addr;
               wrData_d = entry.data;
            end
         end
         StWaitDone: begin
            if (piul1WrDone) begin
               if (piul1WrNack) begin
                  if (retry_q < RETRY_MAX) begin
                     retry_d = retry_q + 4'd1;
                     state_d = StGap;
                     cntLoad = 1'b1;
                  end else begin
                     state_d      = StError;
                     configDone_d = 1'b0;
                  end
               end else begin
                  retry_d = '0;
                  if (expoActive_q) begin
                     expoActive_d = 1'b0;
                     state_d      = StDone;
                     if (!piul1ExposureUpdate) expoPending_d = 1'b0;
                  end else if (index_q == LAST_IDX) begin
                     configDone_d = 1'b1;
                     // Service an exposure queued during the table without dropping Busy
                     if (expoPending_q || piul1ExposureUpdate) begin
                        expoActive_d = 1'b1;
                        state_d      = StGap;
                        cntLoad      = 1'b1;
                     end else begin
                        state_d = StDone;
                     end
                  end else begin
                     index_d = index_q + 5'd1;
                     state_d = StGap;
                     cntLoad = 1'b1;
                  end
               end
            end
         end
         StGap: begin
            if (cntZero) state_d = StIssue;
         end
         StDone, StError: begin
            if (startOk) begin
               state_d      = StPwrupWait;
               configDone_d = 1'b0;
               index_d      = '0;
               cntLoad      = 1'b1;
               cntLoadValue = PWRUP_LOAD;
            end else if (state_q == StDone && expoPending_q) begin
               state_d      = StIssue;
               expoActive_d = 1'b1;
               retry_d      = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge piul1Clock or posedge piul1Reset) begin
      if (piul1Reset) begin
         state_q       <= StIdle;
         index_q       <= '0;
         retry_q       <= '0;
         expoActive_q  <= 1'b0;
         expoPending_q <= 1'b0;
         expoValue_q   <= '0;
         configDone_q  <= 1'b0;
         wrAddr_q      <= '0;
         wrData_q      <= '0;
      end else begin
         state_q       <= state_d;
         index_q       <= index_d;
         retry_q       <= retry_d;
         expoActive_q  <= expoActive_d;
         expoPending_q <= expoPending_d;
         expoValue_q   <= expoValue_d;
         configDone_q  <= configDone_d;
         wrAddr_q      <= wrAddr_d;
         wrData_q      <= wrData_d;
      end
   end

   // Decoded from the async-reset state so WrReq drops the instant reset asserts
   assign poul1WrReq      = (state_q == StWaitDone);
   assign poul1Busy       = state_q inside {StPwrupWait, StIssue, StWaitDone, StGap};
   assign poul1Error      = (state_q == StError);
   assign poul1ConfigDone = configDone_q;
   assign poul8WrAddr     = wrAddr_q;
   assign poul16WrData    = wrData_q;
   assign poul5TableIndex = index_q;

endmodule

// File: tb/tb_d5m_config_sequencer.sv
// Scoreboard bench for d5m_config_sequencer with a simple I2C engine model and NACK injection.
module tb_d5m_config_sequencer;

   localparam int unsigned PWR = 200;
   localparam int unsigned GAP = 8;
`ifdef D5M_CONFIG_SOFT_RESET_EN
   localparam int PRE = 2;
`else
   localparam int PRE = 0;
`endif
   localparam int TBL_N = PRE + 14;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        expoUpd;
   logic [15:0] expoVal;
   logic        wrReq;
   logic [7:0]  wrAddr;
   logic [15:0] wrData;
   logic        wrDone;
   logic        wrNack;
   logic        busy;
   logic        cfgDone;
   logic        err;
   logic [4:0]  tblIdx;

   int checks = 0;
   int errors = 0;
   logic [23:0] expQ[$];
   logic [7:0]  nackAddr = 8'h00;
   int          nackLeft = 0;

   d5m_config_sequencer #(
      .POWERUP_DELAY_CC    (PWR),
      .INTER_WRITE_DELAY_CC(GAP),
      .MAX_RETRIES         (3)
   ) dut (
      .piul1Clock         (clk),
      .piul1Reset         (rst),
      .piul1Start         (start),
      .piul1ExposureUpdate(expoUpd),
      .piul16Exposure     (expoVal),
      .poul1WrReq         (wrReq),
      .poul8WrAddr        (wrAddr),
      .poul16WrData       (wrData),
      .piul1WrDone        (wrDone),
      .piul1WrNack        (wrNack),
      .poul1Busy          (busy),
      .poul1ConfigDone    (cfgDone),
      .poul1Error         (err),
      .poul5TableIndex    (tblIdx)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] expEntry(int i);
      logic [23:0] e;
      int k;
      k = i - PRE;
      if (k < 0) e = (i == 0) ? 24'h0D0001 : 24'h0D0000;
      else begin
         case (k)
            0:  e = 24'h010036;
            1:  e = 24'h020010;
            2:  e = 24'h030797;
            3:  e = 24'h040A1F;
            4:  e = 24'h050000;
            5:  e = 24'h060019;
            6:  e = 24'h090400;
            7:  e = 24'h20C000;
            8:  e = 24'h220000;
            9:  e = 24'h230000;
            10: e = 24'h2B0013;
            11: e = 24'h2C0016;
            12: e = 24'h2D0016;
            13: e = 24'h2E0013;
            default: e = 24'h000000;
         endcase
      end
      return e;
   endfunction

   // Push the table in order; entry `rep` gets `extra` repeated issues
   task automatic pushTable(int rep, int extra);
      for (int i = 0; i < TBL_N; i++) begin
         expQ.push_back(expEntry(i));
         if (i == rep) for (int j = 0; j < extra; j++) expQ.push_back(expEntry(i));
      end
   endtask

   task automatic check(string name, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   task automatic waitIdle(string name);
      int n;
      n = 0;
      while (busy && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check({name, "_busy_timeout"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic pulseStart();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
   endtask

   // Engine model: ack 10 cycles after WrReq, NACK when the address matches the injection plan
   initial begin
      wrDone = 1'b0;
      wrNack = 1'b0;
      forever begin
         @(negedge clk);
         if (wrReq) begin
            repeat (9) @(negedge clk);
            if (wrReq) begin
               wrNack = (wrAddr == nackAddr) && (nackLeft > 0);
               if (wrNack) nackLeft--;
               wrDone = 1'b1;
               @(negedge clk);
               wrDone = 1'b0;
               wrNack = 1'b0;
            end
         end
      end
   end

   // Monitor: every new write request is popped against the scoreboard
   initial begin
      logic        prevReq;
      logic [23:0] cur;
      logic [23:0] held;
      logic [23:0] want;
      prevReq = 1'b0;
      held    = '0;
      forever begin
         @(negedge clk);
         cur = {wrAddr, wrData};
         if (wrReq && !prevReq) begin
            checks++;
            if (expQ.size() == 0) begin
               errors++;
               $display("FAIL write_unexpected: got addr %h data %h, expected no write",
                        wrAddr, wrData);
            end else begin
               want = expQ.pop_front();
               if (cur !== want) begin
                  errors++;
                  $display("FAIL write_order: got %h/%h, expected %h/%h",
                           wrAddr, wrData, want[23:16], want[15:0]);
               end
            end
            held = cur;
         end else if (wrReq && cur !== held) begin
            checks++;
            errors++;
            $display("FAIL write_stable: got %h, expected %h held", cur, held);
         end
         prevReq = wrReq;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got simulation timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst     = 1'b1;
      start   = 1'b0;
      expoUpd = 1'b0;
      expoVal = '0;
      repeat (3) @(negedge clk);
      check("reset_wrreq", {31'd0, wrReq}, 0);
      check("reset_busy", {31'd0, busy}, 0);
      check("reset_done", {31'd0, cfgDone}, 0);
      check("reset_error", {31'd0, err}, 0);
      check("reset_index", {27'd0, tblIdx}, 0);
      check("reset_addrdata", {8'd0, wrAddr, wrData}, 0);

      // 1: power-up sequence, all acked
      pushTable(-1, 0);
      rst = 1'b0;
      n = 0;
      while (!wrReq && n < 1000) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      check("first_req_cycle", n, PWR + 2);
      check("busy_during_cfg", {31'd0, busy}, 1);
      waitIdle("cfg1");
      check("cfg1_done", {31'd0, cfgDone}, 1);
      check("cfg1_error", {31'd0, err}, 0);
      check("cfg1_queue", expQ.size(), 0);

      // 2: entry 3 NACKed twice, then acked
      nackAddr = 8'h04;
      nackLeft = 2;
      pushTable(PRE + 3, 2);
      pulseStart();
      waitIdle("cfg2");
      check("nack2_done", {31'd0, cfgDone}, 1);
      check("nack2_error", {31'd0, err}, 0);
      check("nack2_queue", expQ.size(), 0);

      // 3: entry 5 NACKed 4 times -> error, then Start recovers
      nackAddr = 8'h06;
      nackLeft = 4;
      for (int i = 0; i <= PRE + 5; i++) expQ.push_back(expEntry(i));
      for (int i = 0; i < 3; i++) expQ.push_back(expEntry(PRE + 5));
      pulseStart();
      waitIdle("cfg3");
      check("err_flag", {31'd0, err}, 1);
      check("err_cfgdone", {31'd0, cfgDone}, 0);
      check("err_index", {27'd0, tblIdx}, PRE + 5);
      repeat (300) @(negedge clk);
      check("err_no_req", {31'd0, wrReq}, 0);
      check("err_queue", expQ.size(), 0);
      nackLeft = 0;
      pushTable(-1, 0);
      pulseStart();
      check("restart_error_clr", {31'd0, err}, 0);
      check("restart_index", {27'd0, tblIdx}, 0);
      waitIdle("cfg4");
      check("restart_done", {31'd0, cfgDone}, 1);
      check("restart_queue", expQ.size(), 0);

      // 4: exposure updates in DONE
      expQ.push_back(24'h090400);
      expoVal = 16'h0400;
      expoUpd = 1'b1;
      @(negedge clk);
      expoUpd = 1'b0;
      @(negedge clk);
      check("expo_busy", {31'd0, busy}, 1);
      check("expo_cfgdone_held", {31'd0, cfgDone}, 1);
      waitIdle("expo1");
      check("expo1_queue", expQ.size(), 0);
      expQ.push_back(24'h090800);
      expoVal = 16'h0400;
      expoUpd = 1'b1;
      @(negedge clk);
      expoVal = 16'h0800;
      @(negedge clk);
      expoUpd = 1'b0;
      waitIdle("expo2");
      repeat (50) @(negedge clk);
      check("expo2_queue", expQ.size(), 0);
      check("expo2_done", {31'd0, cfgDone}, 1);

      // 5: exposure requested during the table phase
      pushTable(-1, 0);
      expQ.push_back(24'h090123);
      pulseStart();
      repeat (300) @(negedge clk);
      check("midtable_busy", {31'd0, busy}, 1);
      expoVal = 16'h0123;
      expoUpd = 1'b1;
      @(negedge clk);
      expoUpd = 1'b0;
      waitIdle("cfg5");
      check("midtable_queue", expQ.size(), 0);
      check("midtable_done", {31'd0, cfgDone}, 1);

      // 6: reset while a write is in flight
      expQ.push_back(expEntry(0));
      pulseStart();
      n = 0;
      while (!wrReq && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("rst_req_seen", {31'd0, wrReq}, 1);
      #2 rst = 1'b1;
      #1;
      check("rst_req_drop", {31'd0, wrReq}, 0);
      check("rst_busy_drop", {31'd0, busy}, 0);
      pushTable(-1, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      waitIdle("cfg6");
      check("rst_cfg_done", {31'd0, cfgDone}, 1);
      check("rst_queue", expQ.size(), 0);
      check("rst_index", {27'd0, tblIdx}, TBL_N - 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
